// File: rtl/hashvoodoo_stim_pkg.sv
// Shared types and constants for the hashvoodoo serial stimulus engine.
package hashvoodoo_stim_pkg;
    localparam int FRAME_BITS  = 10;
    localparam int NONCE_BYTES = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_GAP,
        TX_FINISH
    } tx_state_e;

    typedef enum logic [0:0] {
        RX_IDLE,
        RX_FRAME
    } rx_state_e;
endpackage

// File: rtl/hashvoodoo_stim_uart_rx.sv
// Nonce receive monitor: rxd synchroniser, mid-bit frame sampler and LSB-first 32-bit assembler.
// nonce_valid and frame_err are single-cycle pulses with no ready: the consumer samples them that cycle.
module hashvoodoo_stim_uart_rx
    import hashvoodoo_stim_pkg::*;
#(
    parameter int BAUD_DIV        = 16,
    parameter int RX_TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rxd,
    output logic        nonce_valid,
    output logic [31:0] nonce,
    output logic        frame_err,
    output rx_state_e   dbg_rx_state
);
    localparam int BCW = $clog2(BAUD_DIV);
    localparam int TOW = $clog2(RX_TIMEOUT_BITS * BAUD_DIV + 1);
    localparam logic [BCW-1:0] HALF   = BCW'(BAUD_DIV / 2);
    localparam logic [BCW-1:0] LAST   = BCW'(BAUD_DIV - 1);
    localparam logic [TOW-1:0] TO_END = TOW'(RX_TIMEOUT_BITS * BAUD_DIV - 1);
    localparam logic [1:0]     WORD_LAST = 2'(NONCE_BYTES - 1);

    logic [2:0] sync_q, sync_d;
    logic       rx_s, rx_prev;

    rx_state_e      state_q;
    logic [BCW-1:0] cnt_q;
    logic [3:0]     bit_q;
    logic [7:0]     shift_q;
    logic [1:0]     byte_cnt_q;
    logic [23:0]    word_q;
    logic [TOW-1:0] idle_q;
    logic [31:0]    nonce_q;
    logic           nv_q, fe_q;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection.
    always_comb begin
        sync_d  = {sync_q[1:0], rxd};
        rx_s    = sync_q[1];
        rx_prev = sync_q[2];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 3'b111;
        else          sync_q <= sync_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            idle_q     <= '0;
            nonce_q    <= '0;
            nv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            nv_q <= 1'b0;
            fe_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state_q <= RX_FRAME;
                        cnt_q   <= BCW'(1);
                        bit_q   <= '0;
                        idle_q  <= '0;
                    end else if (byte_cnt_q != 2'd0) begin
                        // A stalled partial word is dropped so a later burst starts cleanly.
                        if (idle_q == TO_END) begin
                            byte_cnt_q <= '0;
                            idle_q     <= '0;
                        end else begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
                end
                RX_FRAME: begin
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST) bit_q <= bit_q + 4'd1;
                    if (cnt_q == HALF) begin
                        if (bit_q == 4'd0) begin
                            if (rx_s) state_q <= RX_IDLE;
                        end else if (bit_q < 4'd9) begin
                            shift_q <= {rx_s, shift_q[7:1]};
                        end else begin
                            state_q <= RX_IDLE;
                            idle_q  <= '0;
                            if (!rx_s) begin
                                fe_q       <= 1'b1;
                                byte_cnt_q <= '0;
                            end else if (byte_cnt_q == WORD_LAST) begin
                                nonce_q    <= {shift_q, word_q};
                                nv_q       <= 1'b1;
                                byte_cnt_q <= '0;
                            end else begin
                                word_q     <= {shift_q, word_q[23:8]};
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                            end
                        end
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign nonce_valid  = nv_q;
    assign nonce        = nonce_q;
    assign frame_err    = fe_q;
    assign dbg_rx_state = state_q;
endmodule

// File: rtl/hashvoodoo_uart_stim.sv
// Serial stimulus engine: repeats a buffered work packet on txd and, when HASHVOODOO_STIM_RX_MON_EN
// is defined, decodes golden-nonce words from rxd.
module hashvoodoo_uart_stim
    import hashvoodoo_stim_pkg::*;
#(
    parameter int BAUD_DIV        = 16,
    parameter int PKT_BYTES       = 44,
    parameter int GAP_BITS        = 8,
    parameter int RX_TIMEOUT_BITS = 20
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [$clog2(PKT_BYTES)-1:0] wr_addr,
    input  logic [7:0]                   wr_data,
    input  logic                         start,
    input  logic [7:0]                   repeat_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         txd,
    input  logic                         rxd,
    output logic                         nonce_valid,
    output logic [31:0]                  nonce,
    output logic                         frame_err,
    output tx_state_e                    dbg_tx_state
);
    localparam int AW  = $clog2(PKT_BYTES);
    localparam int BCW = $clog2(BAUD_DIV);
    localparam int GCW = $clog2(GAP_BITS + 1);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [AW-1:0]  BYTE_LAST = AW'(PKT_BYTES - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_BITS - 1);

    tx_state_e      state_q;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]     data_bit_q;
    logic [GCW-1:0] gap_cnt_q;
    logic [AW-1:0]  byte_idx_q;
    logic [7:0]     pkt_left_q, shift_q, cur_byte;
    logic           txd_q, busy_q, done_q;
    logic           bit_end, wr_ok;
    logic [7:0]     mem_q [PKT_BYTES];

    always_comb begin
        bit_end   = (bit_cnt_q == BAUD_LAST);
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
        cur_byte  = mem_q[byte_idx_q];
        wr_ok     = wr_en && !busy_q && (int'(wr_addr) < PKT_BYTES);
    end

    // Buffer is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= TX_IDLE;
            bit_cnt_q  <= '0;
            data_bit_q <= '0;
            gap_cnt_q  <= '0;
            byte_idx_q <= '0;
            pkt_left_q <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (start) begin
                        pkt_left_q <= repeat_cnt;
                        byte_idx_q <= '0;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        if (repeat_cnt == 8'd0) begin
                            state_q <= TX_FINISH;
                        end else begin
                            state_q <= TX_START;
                            txd_q   <= 1'b0;
                        end
                    end
                end
                TX_START: begin
                    bit_cnt_q <= bit_cnt_d;
                    if (bit_end) begin
                        txd_q      <= cur_byte[0];
                        shift_q    <= {1'b0, cur_byte[7:1]};
                        data_bit_q <= '0;
                        state_q    <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    bit_cnt_q <= bit_cnt_d;
                    if (bit_end) begin
                        if (data_bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            txd_q      <= shift_q[0];
                            shift_q    <= {1'b0, shift_q[7:1]};
                            data_bit_q <= data_bit_q + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    bit_cnt_q <= bit_cnt_d;
                    if (bit_end) begin
                        if (byte_idx_q != BYTE_LAST) begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            txd_q      <= 1'b0;
                            state_q    <= TX_START;
                        end else if (pkt_left_q > 8'd1) begin
                            pkt_left_q <= pkt_left_q - 8'd1;
                            byte_idx_q <= '0;
                            gap_cnt_q  <= '0;
                            state_q    <= TX_GAP;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= TX_FINISH;
                        end
                    end
                end
                TX_GAP: begin
                    bit_cnt_q <= bit_cnt_d;
                    if (bit_end) begin
                        if (gap_cnt_q == GAP_LAST) begin
                            txd_q   <= 1'b0;
                            state_q <= TX_START;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 1'b1;
                        end
                    end
                end
                TX_FINISH: begin
                    // Entered with done already high after a packet; an empty request raises it here.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= TX_IDLE;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign txd          = txd_q;
    assign dbg_tx_state = state_q;

`ifdef HASHVOODOO_STIM_RX_MON_EN
    rx_state_e dbg_rx_state;

    hashvoodoo_stim_uart_rx #(
        .BAUD_DIV       (BAUD_DIV),
        .RX_TIMEOUT_BITS(RX_TIMEOUT_BITS)
    ) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .rxd         (rxd),
        .nonce_valid (nonce_valid),
        .nonce       (nonce),
        .frame_err   (frame_err),
        .dbg_rx_state(dbg_rx_state)
    );
`else
    localparam int unused_rx_timeout = RX_TIMEOUT_BITS;
    logic unused_rxd;

    assign unused_rxd  = rxd;
    assign nonce_valid = 1'b0;
    assign nonce       = 32'd0;
    assign frame_err   = 1'b0;
`endif
endmodule

// File: doc/hashvoodoo_uart_stim.md
# hashvoodoo_uart_stim

Parametrised serial stimulus/monitor engine for miner-top benches: drives the miner's RxD line with repeated work packets and decodes the miner's TxD line into golden-nonce words. Sits between the bench sequencer and the miner top's serial pins. It generalises fixed-clock, idle-RxD stimulus into configurable packet length, baud divisor, repeat count and inter-packet gap. It also adds a nonce receive monitor.

## Interface
- BAUD_DIV, 16: clock cycles per serial bit; legal values are 4 or more.
- PKT_BYTES, 44: work-packet length in bytes.
- GAP_BITS, 8: idle bit-times inserted between repeated packets.
- RX_TIMEOUT_BITS, 20: idle bit-times after which a partial nonce word is discarded.
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  packet-buffer write strobe.
- wr_addr  in  $clog2(PKT_BYTES)  packet-buffer byte address.
- wr_data  in  8  packet-buffer byte.
- start  in  1  one-cycle request to begin transmission.
- repeat_cnt  in  8  number of packets to send; sampled with start.
- busy  out  1  transmitter active.
- done  out  1  one-cycle completion pulse.
- txd  out  1  serial out to miner RxD; idles high.
- rxd  in  1  serial in from miner TxD; asynchronous to clk.
- nonce_valid  out  1  one-cycle pulse when nonce is updated.
- nonce  out  32  last received nonce word.
- frame_err  out  1  one-cycle pulse on a bad stop bit.

## Operation
- Packet buffer: PKT_BYTES x 8 storage.
  - Writes are accepted only while busy=0; writes while busy are dropped.
  - Writes with an out-of-range address are dropped.
- TX state machine has six states: IDLE, START, DATA, STOP, GAP, FINISH.
  - IDLE: start=1 latches repeat_cnt. A repeat_cnt of 0 goes directly to FINISH. Otherwise the FSM goes to START with byte index 0. start while busy is ignored.
  - START: txd=0 for one bit-time, then DATA.
  - DATA: 8 bits, LSB first, one bit-time each, then STOP.
  - STOP: txd=1 for one bit-time.
    - If more bytes remain: increment the byte index and go to START.
    - Else if more packets remain: decrement the packet count and go to GAP.
    - Else: go to FINISH.
  - GAP: txd=1 for GAP_BITS bit-times, byte index reset to 0, then START.
  - FINISH: done=1 for one cycle, then IDLE.
- Byte order: address 0 is sent first, address PKT_BYTES-1 last.
- Counters:
  - Bit-time counter counts 0..BAUD_DIV-1 and wraps.
  - Byte index wraps at PKT_BYTES-1.
- RX monitor:
  - rxd passes through a 2-flop synchroniser.
  - A falling edge while idle starts a frame.
  - Each bit is sampled at BAUD_DIV/2 into its bit-time.
  - Stop bit =1: the byte is accepted. Bytes are assembled LSB-first: the first byte becomes nonce[7:0] and the fourth becomes nonce[31:24].
  - Stop bit =0: frame_err pulses, the byte is discarded and the byte count returns to 0.
  - A partial word that sees no new start bit within RX_TIMEOUT_BITS bit-times is discarded; nonce is unchanged.
- Reset value of every output: busy=0, done=0, txd=1, nonce_valid=0, nonce=0, frame_err=0.
- Reset mid-frame forces txd high asynchronously. The packet buffer contents are not cleared.

## Timing
- start asserted at cycle 0: busy=1 and txd=0 from cycle 1.
- Frame length: 10*BAUD_DIV cycles.
- Packet length: PKT_BYTES*10*BAUD_DIV cycles.
- GAP_BITS*BAUD_DIV cycles separate consecutive packets. No gap follows the last packet.
- done pulses the cycle after the last stop bit-time ends. busy falls in the same cycle.
- Total cycles from start to done: R*PKT_BYTES*10*BAUD_DIV + (R-1)*GAP_BITS*BAUD_DIV + 1, where R=repeat_cnt≥1.
- nonce_valid and the nonce update occur 3 cycles after the fourth stop-bit sample: 2 cycles of synchroniser plus 1 register cycle.
- frame_err has the same latency relative to its stop-bit sample.
- TX and RX operate fully independently. Simultaneous traffic in both directions is legal.

## Configuration
- HASHVOODOO_STIM_RX_MON_EN defined: the RX monitor is built.
- Undefined:
  - nonce_valid=0, nonce=0 and frame_err=0 are tied off.
  - rxd is unused.
  - TX behaviour is unchanged.

## Structure
- Package hashvoodoo_stim_pkg holds:
  - the TX state enum;
  - constants FRAME_BITS=10 and NONCE_BYTES=4.
- Sub-module hashvoodoo_stim_uart_rx contains the synchroniser, frame sampler and nonce assembler. It is instantiated only under HASHVOODOO_STIM_RX_MON_EN.

## Test plan
All scenarios use BAUD_DIV=16 and PKT_BYTES=44.
- Reset then idle: all outputs at reset values and txd=1 for 1000 cycles.
- Buffer loaded with bytes 0x00..0x2B, repeat_cnt=1, start:
  - decoded txd stream is 0x00..0x2B in order with correct framing;
  - done occurs exactly 7041 cycles after start.
- repeat_cnt=3, GAP_BITS=8:
  - three identical packets are sent, each gap is 128 cycles of txd=1;
  - done occurs after 21377 cycles.
- repeat_cnt=0: done pulses at cycle 2, txd never falls. start and buffer writes issued mid-packet are ignored, and the packet matches the original contents.
- rxd frames 0xEF, 0xBE, 0xAD, 0xDE:
  - nonce=0xDEADBEEF with one nonce_valid pulse;
  - a 5th frame with its stop bit =0 gives a frame_err pulse and no nonce_valid.
- Other cases:
  - reset_n low mid-DATA: txd=1 immediately;
  - after release, a new start sends the full packet;
  - two RX bytes followed by 400 idle cycles are discarded, and the next four bytes form a clean nonce.
